// File: rtl/imm_pkg.sv
// Shared types for the pipelined immediate generator.
// Type codes, opcode constants, shift funct3 values, XLEN legality check.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_B    = 3'd1,
    IMM_S    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_SH   = 3'd5,
    IMM_Z    = 3'd6,
    IMM_NONE = 3'd7
  } imm_type_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  function automatic bit xlen_ok(int x);
    return (x == 32) || (x == 64);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction in, immediate out.
// master = producer/consumer side, slave = the generator.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  imm_type_e        out_type;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_tag, out_err
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational opcode decode and sign/zero extension to XLEN.
// instr in; imm/itype/err out. IMM_CSR_ZIMM_EN enables CSR zimm type.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_e       itype,
  output logic            err
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic rv64, op32, is_sh, is_z;
  logic is_i, is_s, is_b, is_u, is_j;
  logic signed [31:0] i32, s32, b32, u32, j32;

  assign opc  = instr[6:0];
  assign f3   = instr[14:12];
  assign rv64 = (XLEN == 64);
  assign op32 = rv64 && (opc == OP_IMM32);

  assign is_sh = (opc == OP_IMM || op32) &&
                 (f3 == F3_SLL || f3 == F3_SRX);
`ifdef IMM_CSR_ZIMM_EN
  assign is_z = (opc == OP_SYSTEM) && f3[2];
`else
  assign is_z = 1'b0;
`endif
  assign is_i = !is_sh && !is_z &&
                (opc == OP_IMM || opc == OP_LOAD ||
                 opc == OP_JALR || opc == OP_SYSTEM || op32);
  assign is_s = (opc == OP_STORE);
  assign is_b = (opc == OP_BRANCH);
  assign is_u = (opc == OP_LUI) || (opc == OP_AUIPC);
  assign is_j = (opc == OP_JAL);

  assign i32 = {{20{instr[31]}}, instr[31:20]};
  assign s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b32 = {{19{instr[31]}}, instr[31], instr[7],
                instr[30:25], instr[11:8], 1'b0};
  assign u32 = {instr[31:12], 12'h000};
  assign j32 = {{11{instr[31]}}, instr[31], instr[19:12],
                instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm   = '1;
    itype = IMM_NONE;
    err   = 1'b0;
    unique case (1'b1)
      is_sh: begin
        itype    = IMM_SH;
        imm      = '0;
        imm[4:0] = instr[24:20];
        // RV64 base shifts carry a 6-bit shamt; the *W forms do not
        if (rv64 && opc == OP_IMM) imm[5] = instr[25];
      end
      is_z: begin
        itype    = IMM_Z;
        imm      = '0;
        imm[4:0] = instr[19:15];
      end
      is_i: begin itype = IMM_I; imm = XLEN'(i32); end
      is_s: begin itype = IMM_S; imm = XLEN'(s32); end
      is_b: begin itype = IMM_B; imm = XLEN'(b32); end
      is_u: begin itype = IMM_U; imm = XLEN'(u32); end
      is_j: begin itype = IMM_J; imm = XLEN'(j32); end
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one registered stage, optional skid entry.
// Ports: clk, rst (sync, high), bus (slave). Macro: IMM_CSR_ZIMM_EN.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int SKID  = 1
) (
  input logic           clk,
  input logic           rst,
  imm_gen_pipe_if.slave bus
);
  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] d_imm;
  imm_type_e       d_type;
  logic            d_err;
  logic            push, pop;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr (bus.in_instr),
    .imm   (d_imm),
    .itype (d_type),
    .err   (d_err)
  );

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  if (SKID == 0) begin : g_reg
    assign bus.in_ready = !rst && (!bus.out_valid || bus.out_ready);

    always_ff @(posedge clk) begin
      if (rst) begin
        bus.out_valid <= 1'b0;
        bus.out_imm   <= '0;
        bus.out_type  <= IMM_I;
        bus.out_tag   <= '0;
        bus.out_err   <= 1'b0;
      end else if (push) begin
        bus.out_valid <= 1'b1;
        bus.out_imm   <= d_imm;
        bus.out_type  <= d_type;
        bus.out_tag   <= bus.in_tag;
        bus.out_err   <= d_err;
      end else if (pop) begin
        bus.out_valid <= 1'b0;
      end
    end
  end else begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
    state_e           st;
    logic [XLEN-1:0]  s_imm;
    imm_type_e        s_type;
    logic [TAG_W-1:0] s_tag;
    logic             s_err;

    // Output regs are the head entry; s_* holds the second entry.
    always_ff @(posedge clk) begin
      if (rst) begin
        st            <= EMPTY;
        bus.in_ready  <= 1'b1;
        bus.out_valid <= 1'b0;
        bus.out_imm   <= '0;
        bus.out_type  <= IMM_I;
        bus.out_tag   <= '0;
        bus.out_err   <= 1'b0;
        s_imm         <= '0;
        s_type        <= IMM_I;
        s_tag         <= '0;
        s_err         <= 1'b0;
      end else begin
        unique case (st)
          EMPTY: if (push) begin
            st            <= ONE;
            bus.out_valid <= 1'b1;
            bus.out_imm   <= d_imm;
            bus.out_type  <= d_type;
            bus.out_tag   <= bus.in_tag;
            bus.out_err   <= d_err;
          end
          ONE: if (push && !pop) begin
            st           <= TWO;
            bus.in_ready <= 1'b0;
            s_imm        <= d_imm;
            s_type       <= d_type;
            s_tag        <= bus.in_tag;
            s_err        <= d_err;
          end else if (push) begin
            bus.out_imm  <= d_imm;
            bus.out_type <= d_type;
            bus.out_tag  <= bus.in_tag;
            bus.out_err  <= d_err;
          end else if (pop) begin
            st            <= EMPTY;
            bus.out_valid <= 1'b0;
          end
          TWO: if (pop) begin
            st           <= ONE;
            bus.in_ready <= 1'b1;
            bus.out_imm  <= s_imm;
            bus.out_type <= s_type;
            bus.out_tag  <= s_tag;
            bus.out_err  <= s_err;
          end
          default: st <= EMPTY;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32/SKID=1 and XLEN=64/SKID=0.
// Ports: none. Honors IMM_CSR_ZIMM_EN like the design.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) a_if ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) b_if ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(4), .SKID(1)) u_a (
    .clk (clk), .rst (rst), .bus (a_if)
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(4), .SKID(0)) u_b (
    .clk (clk), .rst (rst), .bus (b_if)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic xfer_a(input logic [31:0] ins, input logic [3:0] tg,
                        output logic ok, output logic [31:0] imm,
                        output logic [2:0] ty, output logic er,
                        output logic [3:0] otg);
    @(negedge clk);
    a_if.out_ready = 1'b1;
    a_if.in_valid  = 1'b1;
    a_if.in_instr  = ins;
    a_if.in_tag    = tg;
    ok = a_if.in_ready;
    @(posedge clk);
    #1 a_if.in_valid = 1'b0;
    @(negedge clk);
    ok  = ok && a_if.out_valid;
    imm = a_if.out_imm;
    ty  = a_if.out_type;
    er  = a_if.out_err;
    otg = a_if.out_tag;
  endtask

  task automatic xfer_b(input logic [31:0] ins, output logic ok,
                        output logic [63:0] imm, output logic [2:0] ty,
                        output logic er);
    @(negedge clk);
    b_if.out_ready = 1'b1;
    b_if.in_valid  = 1'b1;
    b_if.in_instr  = ins;
    b_if.in_tag    = 4'd9;
    ok = b_if.in_ready;
    @(posedge clk);
    #1 b_if.in_valid = 1'b0;
    @(negedge clk);
    ok  = ok && b_if.out_valid;
    imm = b_if.out_imm;
    ty  = b_if.out_type;
    er  = b_if.out_err;
  endtask

  task automatic test_reset();
    a_if.in_valid = 0; a_if.out_ready = 0;
    a_if.in_instr = '0; a_if.in_tag = '0;
    b_if.in_valid = 0; b_if.out_ready = 0;
    b_if.in_instr = '0; b_if.in_tag = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (a_if.out_valid !== 1'b0)
      $display("FAIL rst_a_valid got=%b want=0", a_if.out_valid); else passed++;
    total++; if (a_if.in_ready !== 1'b1)
      $display("FAIL rst_a_ready got=%b want=1", a_if.in_ready); else passed++;
    total++; if (a_if.out_imm !== 32'h0)
      $display("FAIL rst_a_imm got=%h want=0", a_if.out_imm); else passed++;
    total++; if (a_if.out_type !== 3'd0 || a_if.out_tag !== 4'd0 || a_if.out_err !== 1'b0)
      $display("FAIL rst_a_fields got=%0d/%0d/%b want=0/0/0",
               a_if.out_type, a_if.out_tag, a_if.out_err); else passed++;
    total++; if (b_if.out_valid !== 1'b0 || b_if.in_ready !== 1'b1)
      $display("FAIL rst_b got=%b/%b want=0/1", b_if.out_valid, b_if.in_ready); else passed++;
  endtask

  task automatic test_i_b_s();
    logic ok, er; logic [31:0] imm; logic [2:0] ty; logic [3:0] tg;
    xfer_a(32'hFFF00093, 4'd3, ok, imm, ty, er, tg);
    total++; if (!ok || imm !== 32'hFFFFFFFF || ty !== 3'd0 || tg !== 4'd3)
      $display("FAIL i_type got=%b %h %0d %0d want=1 ffffffff 0 3", ok, imm, ty, tg); else passed++;
    // branch -4: imm[11]=1 lives in instr[7]
    xfer_a(32'hFE000EE3, 4'd4, ok, imm, ty, er, tg);
    total++; if (!ok || imm !== 32'hFFFFFFFC || ty !== 3'd1)
      $display("FAIL b_type got=%b %h %0d want=1 fffffffc 1", ok, imm, ty); else passed++;
    // same word with instr[7]=0, so imm[11]=0
    xfer_a(32'hFE000E63, 4'd5, ok, imm, ty, er, tg);
    total++; if (imm !== 32'hFFFFF7FC || ty !== 3'd1)
      $display("FAIL b_type2 got=%h %0d want=fffff7fc 1", imm, ty); else passed++;
    xfer_a(32'hFE112E23, 4'd6, ok, imm, ty, er, tg);
    total++; if (imm !== 32'hFFFFFFFC || ty !== 3'd2)
      $display("FAIL s_type got=%h %0d want=fffffffc 2", imm, ty); else passed++;
  endtask

  task automatic test_u_j();
    logic ok, er; logic [31:0] imm; logic [2:0] ty; logic [3:0] tg;
    logic [63:0] imm64;
    xfer_a(32'h123450B7, 4'd1, ok, imm, ty, er, tg);
    total++; if (imm !== 32'h12345000 || ty !== 3'd3)
      $display("FAIL u_type got=%h %0d want=12345000 3", imm, ty); else passed++;
    xfer_a(32'h008000EF, 4'd2, ok, imm, ty, er, tg);
    total++; if (imm !== 32'h00000008 || ty !== 3'd4)
      $display("FAIL j_type got=%h %0d want=00000008 4", imm, ty); else passed++;
    xfer_b(32'h80000037, ok, imm64, ty, er);
    total++; if (!ok || imm64 !== 64'hFFFFFFFF80000000 || ty !== 3'd3)
      $display("FAIL u64 got=%b %h %0d want=1 ffffffff80000000 3", ok, imm64, ty); else passed++;
    xfer_b(32'hFFF00093, ok, imm64, ty, er);
    total++; if (imm64 !== 64'hFFFFFFFFFFFFFFFF || ty !== 3'd0)
      $display("FAIL i64 got=%h %0d want=ffffffffffffffff 0", imm64, ty); else passed++;
  endtask

  task automatic test_shamt_none();
    logic ok, er; logic [31:0] imm; logic [2:0] ty; logic [3:0] tg;
    logic [63:0] imm64;
    xfer_a(32'h4030D093, 4'd7, ok, imm, ty, er, tg);
    total++; if (imm !== 32'd3 || ty !== 3'd5 || er !== 1'b0)
      $display("FAIL shamt got=%h %0d %b want=3 5 0", imm, ty, er); else passed++;
    xfer_a(32'h03F09093, 4'd7, ok, imm, ty, er, tg);
    total++; if (imm !== 32'd31 || ty !== 3'd5)
      $display("FAIL shamt32 got=%h %0d want=1f 5", imm, ty); else passed++;
    xfer_b(32'h03F09093, ok, imm64, ty, er);
    total++; if (imm64 !== 64'd63 || ty !== 3'd5)
      $display("FAIL shamt64 got=%h %0d want=3f 5", imm64, ty); else passed++;
    xfer_a(32'h00000033, 4'd8, ok, imm, ty, er, tg);
    total++; if (imm !== 32'hFFFFFFFF || ty !== 3'd7 || er !== 1'b1)
      $display("FAIL none got=%h %0d %b want=ffffffff 7 1", imm, ty, er); else passed++;
    // OP-IMM-32 exists only on RV64
    xfer_a(32'h0000001B, 4'd8, ok, imm, ty, er, tg);
    total++; if (ty !== 3'd7 || er !== 1'b1)
      $display("FAIL w32 got=%0d %b want=7 1", ty, er); else passed++;
    xfer_b(32'h0000001B, ok, imm64, ty, er);
    total++; if (imm64 !== 64'd0 || ty !== 3'd0 || er !== 1'b0)
      $display("FAIL w64 got=%h %0d %b want=0 0 0", imm64, ty, er); else passed++;
  endtask

  task automatic test_csr();
    logic ok, er; logic [31:0] imm; logic [2:0] ty; logic [3:0] tg;
    logic [31:0] w_imm; logic [2:0] w_ty;
`ifdef IMM_CSR_ZIMM_EN
    w_imm = 32'd5;   w_ty = 3'd6;
`else
    w_imm = 32'h300; w_ty = 3'd0;
`endif
    xfer_a(32'h3002D073, 4'd9, ok, imm, ty, er, tg);
    total++; if (imm !== w_imm || ty !== w_ty)
      $display("FAIL csr got=%h %0d want=%h %0d", imm, ty, w_imm, w_ty); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [3];
    logic [31:0] wimm [3];
    logic [3:0] got_tag [$];
    logic [31:0] got_imm [$];
    int got_cyc [$];
    logic acc, sent;
    ins[0] = 32'hFFF00093; wimm[0] = 32'hFFFFFFFF;
    ins[1] = 32'h123450B7; wimm[1] = 32'h12345000;
    ins[2] = 32'h008000EF; wimm[2] = 32'h00000008;
    @(negedge clk);
    a_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_instr = ins[i];
      a_if.in_tag   = 4'(i + 1);
      acc = a_if.in_ready;
      total++; if (acc !== 1'b1)
        $display("FAIL b2b_acc%0d got=%b want=1", i + 1, acc); else passed++;
      @(negedge clk);
    end
    a_if.in_instr = ins[2];
    a_if.in_tag   = 4'd3;
    for (int k = 0; k < 2; k++) begin
      total++; if (a_if.in_ready !== 1'b0 || a_if.out_valid !== 1'b1 || a_if.out_tag !== 4'd1)
        $display("FAIL b2b_full%0d got=%b/%b/%0d want=0/1/1",
                 k, a_if.in_ready, a_if.out_valid, a_if.out_tag); else passed++;
      @(negedge clk);
    end
    a_if.out_ready = 1'b1;
    sent = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (a_if.out_valid) begin
        got_tag.push_back(a_if.out_tag);
        got_imm.push_back(a_if.out_imm);
        got_cyc.push_back(c);
      end
      acc = a_if.in_valid && a_if.in_ready;
      @(posedge clk);
      #1 if (acc) begin a_if.in_valid = 1'b0; sent = 1'b1; end
      @(negedge clk);
    end
    total++; if (!sent || got_tag.size() != 3)
      $display("FAIL b2b_count got=%0d sent=%b want=3 sent=1", got_tag.size(), sent); else passed++;
    for (int i = 0; i < 3; i++) begin
      if (i < got_tag.size()) begin
        total++; if (got_tag[i] !== 4'(i + 1) || got_imm[i] !== wimm[i] || got_cyc[i] != i)
          $display("FAIL b2b_out%0d got=%0d %h c%0d want=%0d %h c%0d",
                   i, got_tag[i], got_imm[i], got_cyc[i], i + 1, wimm[i], i); else passed++;
      end
    end
  endtask

  task automatic test_b_stall();
    @(negedge clk);
    b_if.out_ready = 1'b0;
    b_if.in_valid  = 1'b1;
    b_if.in_instr  = 32'h123450B7;
    b_if.in_tag    = 4'd7;
    @(posedge clk);
    #1 b_if.in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++; if (b_if.in_ready !== 1'b0 || b_if.out_valid !== 1'b1 ||
                   b_if.out_tag !== 4'd7 || b_if.out_imm !== 64'h12345000)
        $display("FAIL b_stall got=%b/%b/%0d/%h want=0/1/7/12345000",
                 b_if.in_ready, b_if.out_valid, b_if.out_tag, b_if.out_imm); else passed++;
    end
    b_if.out_ready = 1'b1;
    #1;
    total++; if (b_if.in_ready !== 1'b1)
      $display("FAIL b_release got=%b want=1", b_if.in_ready); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_instr = 32'h00000013;
      a_if.in_tag   = 4'(i + 4);
      @(negedge clk);
    end
    a_if.in_valid = 1'b0;
    total++; if (a_if.in_ready !== 1'b0 || a_if.out_tag !== 4'd4)
      $display("FAIL rm_full got=%b/%0d want=0/4", a_if.in_ready, a_if.out_tag); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (a_if.out_valid !== 1'b0 || a_if.in_ready !== 1'b1)
      $display("FAIL rm_after got=%b/%b want=0/1", a_if.out_valid, a_if.in_ready); else passed++;
    a_if.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (a_if.out_valid) seen++;
    end
    total++; if (seen != 0)
      $display("FAIL rm_stale got=%0d want=0", seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_i_b_s();
    test_u_j();
    test_shamt_none();
    test_csr();
    test_back_to_back();
    test_b_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
